// File: rtl/aes_keysched_ctrl.sv
// AES-128 key-schedule sequencer: expands a cipher key into NR+1 round keys and serves them on a registered read port.
// Optional build macro KEYSCHED_SKIP_SAME_KEY_EN skips re-expansion when the key reloaded in DONE equals rk[0].

module KeyExpSub_Byte16 (
    input  logic [127:0] prev_key,
    input  logic [7:0]   round,
    output logic [127:0] next_key
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        logic [7:0] inv;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        inv = r;
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [7:0] idx);
        logic [7:0] r;
        case (idx)
            8'd1:    r = 8'h01;
            8'd2:    r = 8'h02;
            8'd3:    r = 8'h04;
            8'd4:    r = 8'h08;
            8'd5:    r = 8'h10;
            8'd6:    r = 8'h20;
            8'd7:    r = 8'h40;
            8'd8:    r = 8'h80;
            8'd9:    r = 8'h1b;
            8'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0   = prev_key[31:0];
        w1   = prev_key[63:32];
        w2   = prev_key[95:64];
        w3   = prev_key[127:96];
        // First byte of a word lives in [31:24], so RotWord is a left rotate by 8.
        rot  = {w3[23:0], w3[31:24]};
        temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
               ^ {rcon(round), 24'h000000};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        next_key = {n3, n2, n1, n0};
    end

endmodule

module aes_keysched_ctrl #(
    parameter int NR     = 10,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [127:0]      key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              busy,
    output logic              keys_ready,
    input  logic              rk_rd_en,
    input  logic [ADDR_W-1:0] rk_addr,
    output logic [127:0]      rk_data,
    output logic              rk_data_valid
);

    localparam int CNT_W = $clog2(NR + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NR);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [127:0]     prev;
    logic [127:0]     rk [0:NR];
    logic [127:0]     next_key;
    logic             accept;
    logic             same_key;
    logic             start;

    KeyExpSub_Byte16 u_datapath (
        .prev_key (prev),
        .round    (8'(cnt)),
        .next_key (next_key)
    );

`ifdef KEYSCHED_SKIP_SAME_KEY_EN
    assign same_key = (state_q == DONE) && (key_in == rk[0]);
`else
    assign same_key = 1'b0;
`endif

    assign accept = key_valid && key_ready;
    assign start  = accept && !same_key;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        key_ready = 1'b1;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = EXPAND;
            end
            EXPAND: begin
                key_ready = 1'b0;
                busy      = 1'b1;
                if (cnt == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                if (start) state_d = EXPAND;
            end
            default: state_d = IDLE;
        endcase
    end

    // Key register file and expansion bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            prev       <= '0;
            keys_ready <= 1'b0;
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
        end else if (start) begin
            rk[0]      <= key_in;
            prev       <= key_in;
            cnt        <= CNT_W'(1);
            keys_ready <= 1'b0;
        end else if (state_q == EXPAND) begin
            rk[cnt] <= next_key;
            prev    <= next_key;
            if (cnt == CNT_LAST) begin
                cnt        <= '0;
                keys_ready <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Registered read: sees the array before any same-edge write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_data       <= '0;
            rk_data_valid <= 1'b0;
        end else begin
            rk_data_valid <= rk_rd_en;
            if (rk_rd_en) rk_data <= (rk_addr <= ADDR_LAST) ? rk[rk_addr] : 128'h0;
        end
    end

endmodule

// File: tb/tb_aes_keysched_ctrl.sv
// Directed bench for aes_keysched_ctrl: FIPS-197 and all-zero key schedules, read-port scoreboard, reset and reload timing.

module tb_aes_keysched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key_in = '0;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic         busy;
    logic         keys_ready;
    logic         rk_rd_en = 1'b0;
    logic [3:0]   rk_addr = '0;
    logic [127:0] rk_data;
    logic         rk_data_valid;

    int checks = 0;
    int failures = 0;
    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;

    localparam logic [127:0] FIPS_KEY = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    aes_keysched_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_in        (key_in),
        .key_valid     (key_valid),
        .key_ready     (key_ready),
        .busy          (busy),
        .keys_ready    (keys_ready),
        .rk_rd_en      (rk_rd_en),
        .rk_addr       (rk_addr),
        .rk_data       (rk_data),
        .rk_data_valid (rk_data_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] fips_rk(input int i);
        case (i)
            0:  return 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
            1:  return 128'h2a6c7605_23a33939_88542cb1_a0fafe17;
            2:  return 128'h7359f67f_5935807a_7a96b943_f2c295f2;
            3:  return 128'h6d7a883b_1e237e44_4716fe3e_3d80477d;
            4:  return 128'hdb0bad00_b671253b_a8525b7f_ef44a541;
            5:  return 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8;
            6:  return 128'hca0093fd_dbf98641_110b3efd_6d88a37a;
            7:  return 128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e;
            8:  return 128'h7f8d292f_312bf560_b58dbad2_ead27321;
            9:  return 128'h575c006e_28d12941_19fadc21_ac7766f3;
            10: return 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;
            default: return 128'h0;
        endcase
    endfunction

    function automatic logic [127:0] zero_rk(input int i);
        case (i)
            1:  return 128'h62636363_62636363_62636363_62636363;
            2:  return 128'hf9fbfbaa_9b9898c9_f9fbfbaa_9b9898c9;
            10: return 128'h6f8f188e_23e951cf_3e92e211_b4ef5bcb;
            default: return 128'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issue one read strobe; the expected data goes to the scoreboard.
    task automatic rd(input logic [3:0] a, input logic [127:0] e);
        rk_rd_en = 1'b1;
        rk_addr  = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rk_rd_en = 1'b0;
    endtask

    task automatic rd_fips_burst();
        for (int i = 0; i <= 10; i++) rd(4'(i), fips_rk(i));
        rd(4'd11, 128'h0);
        rd(4'd15, 128'h0);
    endtask

    // Accept a key and time keys_ready; optionally pulse another key at a given cycle.
    task automatic load_and_time(input string name, input logic [127:0] k,
                                 input int inject_at, input logic [127:0] alt);
        int lat;
        logic kr_seen;
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        chk({name, "_keys_ready_drop"}, 128'(keys_ready), 128'(1'b0));
        chk({name, "_busy_after_accept"}, 128'(busy), 128'(1'b1));
        lat = 0;
        kr_seen = 1'b0;
        while (!keys_ready && lat < 40) begin
            if (key_ready) kr_seen = 1'b1;
            if (lat == inject_at) begin
                key_in    = alt;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        key_valid = 1'b0;
        chk({name, "_latency"}, 128'(lat), 128'(10));
        chk({name, "_key_ready_low_in_expand"}, 128'(kr_seen), 128'(1'b0));
        chk({name, "_busy_done"}, 128'(busy), 128'(1'b0));
        chk({name, "_key_ready_done"}, 128'(key_ready), 128'(1'b1));
    endtask

    always @(negedge clk) begin
        if (rst_n && rk_data_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected got=%h exp=no_pending_read", rk_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rk_data !== mon_exp) begin
                    failures++;
                    $display("FAIL rd_data got=%h exp=%h", rk_data, mon_exp);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(key_ready), 128'(1'b1));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_keys_ready", 128'(keys_ready), 128'(1'b0));
        chk("rst_rk_data", rk_data, 128'h0);
        chk("rst_rk_data_valid", 128'(rk_data_valid), 128'(1'b0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i <= 10; i++) rd(4'(i), 128'h0);
        @(posedge clk);
        #1;

        // FIPS key with a competing key pulsed mid-expansion.
        load_and_time("fips", FIPS_KEY, 3, ZERO_KEY);
        rd_fips_burst();
        repeat (2) @(posedge clk);
        #1;
        chk("done_holds_keys_ready", 128'(keys_ready), 128'(1'b1));

        load_and_time("reload_zero", ZERO_KEY, -1, ZERO_KEY);
        rd(4'd0, 128'h0);
        rd(4'd1, zero_rk(1));
        rd(4'd2, zero_rk(2));
        rd(4'd10, zero_rk(10));

`ifdef KEYSCHED_SKIP_SAME_KEY_EN
        key_in    = ZERO_KEY;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        chk("same_key_keys_ready", 128'(keys_ready), 128'(1'b1));
        chk("same_key_busy", 128'(busy), 128'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        chk("same_key_keys_ready_held", 128'(keys_ready), 128'(1'b1));
        rd(4'd1, zero_rk(1));
`else
        load_and_time("same_key", ZERO_KEY, -1, ZERO_KEY);
        rd(4'd10, zero_rk(10));
`endif

        // Async reset part way through an expansion.
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        rd(4'd0, FIPS_KEY);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_key_ready", 128'(key_ready), 128'(1'b1));
        chk("arst_busy", 128'(busy), 128'(1'b0));
        chk("arst_keys_ready", 128'(keys_ready), 128'(1'b0));
        chk("arst_rk_data", rk_data, 128'h0);
        chk("arst_rk_data_valid", 128'(rk_data_valid), 128'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_keys_ready_after", 128'(keys_ready), 128'(1'b0));
        for (int i = 0; i <= 10; i++) rd(4'(i), 128'h0);

        load_and_time("after_arst", FIPS_KEY, -1, ZERO_KEY);
        rd_fips_burst();
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_keysched_ctrl.md
Name: aes_keysched_ctrl

Overview:
- Sequencer for the AES-128 single-round key-expansion datapath (KeyExpSub_Byte16, instantiated internally).
- Accepts a 128-bit cipher key, iterates the datapath once per clock to produce round keys 1..NR, and stores all NR+1 round keys in an internal register file.
- Serves those keys to the AES-CTR round core through a registered read port.
- Sits between the key-load interface (AXI-Lite register block) and the encryption pipeline.

Parameters:
- NR, 10, number of expansion rounds (AES-128). Round keys stored = NR+1.
- ADDR_W, 4, width of the round-key read address. Must satisfy 2^ADDR_W >= NR+1.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_in  in  128  cipher key. Word w0 is at [31:0] and w3 is at [127:96]. Within a word, the first byte is at [31:24].
- key_valid  in  1  key_in is valid.
- key_ready  out  1  controller can accept a key.
- busy  out  1  expansion in progress.
- keys_ready  out  1  all NR+1 round keys are valid.
- rk_rd_en  in  1  round-key read strobe.
- rk_addr  in  ADDR_W  round index 0..NR.
- rk_data  out  128  round key, registered, same word ordering as key_in.
- rk_data_valid  out  1  rk_data is valid this cycle.

Behaviour:
- Reset (async assert, sync release): state=IDLE, round counter=0, all round-key registers=0, key_ready=1, busy=0, keys_ready=0, rk_data=0, rk_data_valid=0.
- FSM states: IDLE, EXPAND, DONE.
- key_ready = 1 in IDLE and DONE, 0 in EXPAND.
- Key acceptance: a key is accepted on the edge where key_valid && key_ready. On that edge:
  - rk[0] <= key_in
  - prev <= key_in
  - cnt <= 1
  - keys_ready <= 0
  - state <= EXPAND
  - Applies from both IDLE and DONE. Loading in DONE invalidates the previous schedule.
- EXPAND, each edge:
  - The datapath computes from prev with round index input = cnt (8-bit, zero-extended).
  - rk[cnt] <= result; prev <= result.
  - If cnt==NR: state <= DONE, keys_ready <= 1, cnt <= 0. Otherwise cnt <= cnt+1.
- Latency: keys_ready rises exactly NR edges after the accept edge (10 for AES-128). busy = (state==EXPAND).
- key_valid while in EXPAND is ignored, because key_ready=0. The source holds the key until the handshake completes.
- Read port:
  - On an edge with rk_rd_en=1: rk_data <= rk[rk_addr] and rk_data_valid <= 1. Otherwise rk_data_valid <= 0 and rk_data holds its value.
  - Read latency is 1 cycle; back-to-back reads run at 1 per cycle.
  - rk_addr > NR returns 128'h0 with rk_data_valid=1.
  - Reads are allowed in any state. Contents are only guaranteed when keys_ready=1.
  - A read in the same cycle as the write to that index returns the old value (write and read both registered).
- Reset mid-EXPAND: immediately returns to IDLE and clears all keys. keys_ready stays 0 until a fresh full expansion completes.
- Round keys never change outside the accept edge and EXPAND. DONE holds indefinitely.

Optional Feature:
- Macro: KEYSCHED_SKIP_SAME_KEY_EN.
- When defined:
  - A key accepted in DONE is compared with rk[0].
  - If equal: no expansion. State stays DONE, keys_ready stays 1 without dropping, and rk contents are unchanged. The handshake still completes (key_ready=1).
  - If different: normal expansion.
  - From IDLE, expansion always runs.
- When undefined: every accepted key triggers a full NR-cycle expansion and keys_ready drops for NR cycles.

Test Plan:
- Reset check: rst_n low then release -> key_ready=1, busy=0, keys_ready=0. Read of addr 0..10 -> rk_data=0, rk_data_valid=1 one cycle after each strobe.
- FIPS-197 vector: key_in=128'h09cf4f3c_abf71588_28aed2a6_2b7e1516 -> keys_ready exactly 10 cycles after accept. Then:
  - rk[1] = 128'h2a6c7605_23a33939_88542cb1_a0fafe17
  - rk[10] = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8
  - rk[0] = key_in
- Backpressure: key_valid pulsed during EXPAND with a different key -> ignored. Schedule matches the first key, and key_ready=0 throughout the 10 cycles.
- Reload in DONE with a new key -> keys_ready falls on the accept edge and rises 10 cycles later. With KEYSCHED_SKIP_SAME_KEY_EN and an identical key, keys_ready stays 1 continuously.
- Async reset asserted at cnt=5 -> all outputs reach reset values without a clock edge. A subsequent load completes a correct full schedule.
- Read port: back-to-back rk_rd_en with addr 0,1,...,10,11,15 -> data one cycle later in order. addr 11 and 15 return 0.
